// File: rtl/soundweb_pkg.sv
// Shared definitions for the Soundweb serial transmit path.
//   MAX_BYTES   : default packet buffer depth in bytes
//   STX / ETX   : framing bytes used by the Soundweb packet encoder
//   seq_state_t : transmit sequencer FSM states
package soundweb_pkg;

  localparam int unsigned MAX_BYTES = 29;

  localparam logic [7:0] STX = 8'h02;
  localparam logic [7:0] ETX = 8'h03;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_NEXT,
    ST_FINISH
  } seq_state_t;

endpackage

// File: rtl/soundweb_uart_tx.sv
// 8N1 UART transmitter for one byte per load strobe.
//   clk        : clock, rising edge
//   reset_n    : synchronous active-low reset
//   cancel     : drop any frame in progress, line returns high
//   load       : start a new frame with data (accepted idle or in the last stop-bit cycle)
//   data       : byte to send, LSB first
//   tx         : registered serial line, idle high
//   frame_done : high during the final cycle of the stop bit
module soundweb_uart_tx #(
  parameter int unsigned BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cancel,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       frame_done
);

  localparam int unsigned   CW        = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [3:0]    BIT_STOP  = 4'd9;

  logic          active;
  logic [CW-1:0] baud_cnt;
  logic [3:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          line_bit;

  // Bit 0 is the start bit, 1..8 data (shreg[0] is the current data bit), 9 stop.
  always_comb begin
    line_bit = 1'b1;
    if (active) begin
      if (bit_cnt == 4'd0) begin
        line_bit = 1'b0;
      end else if (bit_cnt != BIT_STOP) begin
        line_bit = shreg[0];
      end
    end
  end

  assign frame_done = active && (bit_cnt == BIT_STOP) && (baud_cnt == BAUD_LAST);

  // tx follows the counters by one cycle, so every bit keeps its full width.
  always_ff @(posedge clk) begin
    if (!reset_n || cancel) begin
      active   <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
    end else begin
      tx <= line_bit;
      if (load) begin
        active   <= 1'b1;
        baud_cnt <= '0;
        bit_cnt  <= '0;
        shreg    <= data;
      end else if (active) begin
        if (baud_cnt == BAUD_LAST) begin
          baud_cnt <= '0;
          if (bit_cnt != 4'd0) begin
            shreg <= {1'b0, shreg[7:1]};
          end
          if (bit_cnt == BIT_STOP) begin
            active  <= 1'b0;
            bit_cnt <= '0;
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
          end
        end else begin
          baud_cnt <= baud_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/soundweb_tx_sequencer.sv
// Sends a buffered Soundweb packet as back-to-back 8N1 frames.
//   clk      : clock, rising edge
//   reset_n  : synchronous active-low reset
//   packet   : packet bytes, byte 0 in the MSBs
//   pkt_len  : number of valid bytes, 1..MAX_BYTES
//   start    : one-cycle transmit request (ignored while busy)
//   abort    : cancel the transfer in progress
//   tx       : serial line, idle high
//   busy     : transfer in progress
//   done     : one-cycle pulse as the last stop bit completes
//   err      : one-cycle pulse on a start with an illegal pkt_len
//   byte_idx : index of the byte on the line, 0 when idle
// The first start bit appears two edges after start is sampled and busy
// stays high for 2 + pkt_len*10*BAUD_DIV cycles.
module soundweb_tx_sequencer #(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned BAUD      = 115_200,
  parameter int unsigned MAX_BYTES = soundweb_pkg::MAX_BYTES
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [8*MAX_BYTES-1:0] packet,
  input  logic [4:0]             pkt_len,
  input  logic                   start,
  input  logic                   abort,
  output logic                   tx,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [4:0]             byte_idx
);

  import soundweb_pkg::*;

  localparam int unsigned BAUD_DIV = (CLK_HZ + BAUD / 2) / BAUD;

  seq_state_t             state;
  logic [8*MAX_BYTES-1:0] pkt_buf;
  logic [4:0]             len_q;
  logic [4:0]             sel_idx;
  logic [7:0]             uart_byte;
  logic                   uart_load;
  logic                   frame_done;
  logic                   cancel;
  logic                   more;
  logic                   len_ok;

  assign len_ok = (pkt_len != 5'd0) && (32'(pkt_len) <= MAX_BYTES);
  assign more   = ({1'b0, byte_idx} + 6'd1) < {1'b0, len_q};
  assign cancel = abort && (state != ST_IDLE);

  // The next byte is handed to the UART in the last stop-bit cycle so frames
  // abut; NEXT then only advances byte_idx, which lands on the same edge as
  // the new start bit because tx lags the UART counters by one cycle.
  assign sel_idx   = (state == ST_LOAD) ? byte_idx : byte_idx + 5'd1;
  assign uart_load = (state == ST_LOAD) || ((state == ST_SHIFT) && frame_done && more);

  always_comb begin
    uart_byte = '0;
    for (int unsigned i = 0; i < MAX_BYTES; i++) begin
      if (sel_idx == 5'(i)) begin
        uart_byte = pkt_buf[8*(MAX_BYTES-1-i) +: 8];
      end
    end
  end

  soundweb_uart_tx #(
    .BAUD_DIV (BAUD_DIV)
  ) u_uart (
    .clk        (clk),
    .reset_n    (reset_n),
    .cancel     (cancel),
    .load       (uart_load),
    .data       (uart_byte),
    .tx         (tx),
    .frame_done (frame_done)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      pkt_buf  <= '0;
      len_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      byte_idx <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (cancel) begin
        state    <= ST_IDLE;
        busy     <= 1'b0;
        byte_idx <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              if (len_ok) begin
                pkt_buf  <= packet;
                len_q    <= pkt_len;
                byte_idx <= '0;
                busy     <= 1'b1;
                state    <= ST_LOAD;
              end else begin
                err <= 1'b1;
              end
            end
          end
          ST_LOAD: state <= ST_SHIFT;
          ST_SHIFT: begin
            if (frame_done) begin
              state <= more ? ST_NEXT : ST_FINISH;
            end
          end
          ST_NEXT: begin
            byte_idx <= byte_idx + 5'd1;
            state    <= ST_SHIFT;
          end
          ST_FINISH: begin
            done     <= 1'b1;
            busy     <= 1'b0;
            byte_idx <= '0;
            state    <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_soundweb_tx_sequencer.sv
// Self-checking bench for soundweb_tx_sequencer at CLK_HZ=1000, BAUD=100.
// Expected bytes are queued when a transfer is launched; a serial receiver
// decodes tx and checks every frame against that queue.
module tb_soundweb_tx_sequencer;

  localparam int unsigned MAXB = 29;
  localparam int unsigned DIV  = 10;

  logic            clk     = 1'b0;
  logic            reset_n = 1'b0;
  logic            start   = 1'b0;
  logic            abort   = 1'b0;
  logic [8*MAXB-1:0] packet = '0;
  logic [4:0]      pkt_len = '0;
  logic            tx, busy, done, err;
  logic [4:0]      byte_idx;

  int         check_cnt   = 0;
  int         pass_cnt    = 0;
  int         err_pulses  = 0;
  int         done_pulses = 0;
  logic [7:0] exp_q[$];
  bit         rx_discard  = 1'b0;

  soundweb_tx_sequencer #(
    .CLK_HZ    (1000),
    .BAUD      (100),
    .MAX_BYTES (MAXB)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .packet   (packet),
    .pkt_len  (pkt_len),
    .start    (start),
    .abort    (abort),
    .tx       (tx),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .byte_idx (byte_idx)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (err === 1'b1) err_pulses++;
    if (done === 1'b1) done_pulses++;
  end

  // Serial receiver: mid-bit sampling on falling edges.
  initial begin : rx_monitor
    logic [7:0] b;
    logic [7:0] e;
    logic       st;
    logic       sp;
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        repeat (4) @(negedge clk);
        st = tx;
        for (int k = 0; k < 8; k++) begin
          repeat (DIV) @(negedge clk);
          b[k] = tx;
        end
        repeat (DIV) @(negedge clk);
        sp = tx;
        if (!rx_discard) begin
          check_cnt++;
          if (exp_q.size() == 0) begin
            $display("FAIL rx_frame: got byte %02h, expected no frame", b);
          end else begin
            e = exp_q.pop_front();
            if (b !== e || st !== 1'b0 || sp !== 1'b1)
              $display("FAIL rx_frame: got byte %02h start=%b stop=%b, expected %02h start=0 stop=1", b, st, sp, e);
            else
              pass_cnt++;
          end
        end
      end
    end
  end

  function automatic logic [8*MAXB-1:0] make_pkt(input int unsigned base, input int unsigned n);
    logic [8*MAXB-1:0] p;
    p = '0;
    for (int unsigned i = 0; i < n; i++) p[8*(MAXB-1-i) +: 8] = 8'(base + i);
    return p;
  endfunction

  // Drives a one-cycle start; returns on the falling edge after it was sampled.
  task automatic launch(input logic [8*MAXB-1:0] p, input int unsigned len, input int unsigned n_push);
    @(negedge clk);
    packet  = p;
    pkt_len = 5'(len);
    start   = 1'b1;
    for (int unsigned i = 0; i < n_push; i++) exp_q.push_back(p[8*(MAXB-1-i) +: 8]);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output int busy_cycles, output int dn, output bit to);
    busy_cycles = 0;
    dn = 0;
    to = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (done === 1'b1) dn++;
      if (busy !== 1'b1) begin
        to = 1'b0;
        break;
      end
      busy_cycles++;
      @(negedge clk);
    end
    @(negedge clk);
    if (done === 1'b1) dn++;
  endtask

  task automatic wait_idx(input logic [4:0] target, input int budget, output bit to);
    to = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (byte_idx === target) begin
        to = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_cnt++;
    if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || byte_idx !== 5'd0)
      $display("FAIL reset_state: tx=%b busy=%b done=%b err=%b idx=%0d, expected 1 0 0 0 0", tx, busy, done, err, byte_idx);
    else pass_cnt++;
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [9:0] frame;
    int bad;
    int busy_lo;
    frame   = {1'b1, 8'h02, 1'b0};
    bad     = 0;
    busy_lo = 0;
    launch(make_pkt(8'h02, 1), 1, 1);
    check_cnt++;
    if (busy !== 1'b1 || tx !== 1'b1) $display("FAIL single_accept: busy=%b tx=%b, expected busy=1 tx=1", busy, tx);
    else pass_cnt++;
    @(negedge clk);
    check_cnt++;
    if (tx !== 1'b1) $display("FAIL single_edge1: tx=%b, expected 1", tx);
    else pass_cnt++;
    @(negedge clk);
    check_cnt++;
    if (tx !== 1'b0) $display("FAIL single_start_edge2: tx=%b, expected 0", tx);
    else pass_cnt++;
    for (int i = 0; i < 10 * int'(DIV); i++) begin
      if (tx !== frame[i / int'(DIV)]) bad++;
      if (busy !== 1'b1) busy_lo++;
      @(negedge clk);
    end
    check_cnt++;
    if (bad != 0 || busy_lo != 0) $display("FAIL single_frame: %0d wrong bits %0d busy-low cycles, expected 0 0", bad, busy_lo);
    else pass_cnt++;
    check_cnt++;
    if (done !== 1'b1 || busy !== 1'b0 || tx !== 1'b1 || byte_idx !== 5'd0)
      $display("FAIL single_finish: done=%b busy=%b tx=%b idx=%0d, expected 1 0 1 0", done, busy, tx, byte_idx);
    else pass_cnt++;
    @(negedge clk);
    check_cnt++;
    if (done !== 1'b0) $display("FAIL single_done_width: done=%b, expected 0", done);
    else pass_cnt++;
    check_cnt++;
    if (exp_q.size() != 0) $display("FAIL single_scoreboard: %0d bytes pending, expected 0", exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_long();
    int cycles, dn, steps, bad_step, bad_align;
    logic [4:0] prev;
    bit to;
    cycles = 0; dn = 0; steps = 0; bad_step = 0; bad_align = 0; prev = '0; to = 1'b1;
    launch(make_pkt(8'h00, 29), 29, 29);
    for (int i = 0; i < 4000; i++) begin
      if (done === 1'b1) dn++;
      if (busy !== 1'b1) begin
        to = 1'b0;
        break;
      end
      cycles++;
      if (byte_idx !== prev) begin
        if (byte_idx === prev + 5'd1) steps++;
        else bad_step++;
        if (tx !== 1'b0) bad_align++;
        prev = byte_idx;
      end
      @(negedge clk);
    end
    @(negedge clk);
    if (done === 1'b1) dn++;
    check_cnt++;
    if (to || cycles != 2 + 29 * 10 * int'(DIV)) $display("FAIL long_busy_cycles: got %0d timeout=%b, expected %0d", cycles, to, 2 + 29 * 10 * int'(DIV));
    else pass_cnt++;
    check_cnt++;
    if (dn != 1) $display("FAIL long_done_count: got %0d, expected 1", dn);
    else pass_cnt++;
    check_cnt++;
    if (steps != 28 || bad_step != 0 || prev != 5'd28) $display("FAIL long_idx_steps: steps=%0d bad=%0d last=%0d, expected 28 0 28", steps, bad_step, prev);
    else pass_cnt++;
    check_cnt++;
    if (bad_align != 0) $display("FAIL long_idx_align: %0d index changes off a start bit, expected 0", bad_align);
    else pass_cnt++;
    check_cnt++;
    if (exp_q.size() != 0) $display("FAIL long_scoreboard: %0d bytes pending, expected 0", exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_err();
    int e, bad;
    int lens[2];
    lens[0] = 0;
    lens[1] = 30;
    foreach (lens[j]) begin
      launch(make_pkt(8'h10, 29), lens[j], 0);
      e = 0;
      bad = 0;
      for (int i = 0; i < 6; i++) begin
        if (err === 1'b1) e++;
        if (tx !== 1'b1 || busy !== 1'b0) bad++;
        @(negedge clk);
      end
      check_cnt++;
      if (e != 1) $display("FAIL err_pulse_len%0d: %0d err cycles, expected 1", lens[j], e);
      else pass_cnt++;
      check_cnt++;
      if (bad != 0) $display("FAIL err_idle_len%0d: %0d cycles with tx/busy active, expected 0", lens[j], bad);
      else pass_cnt++;
    end
  endtask

  task automatic test_busy_ignore();
    int e0, d0, bc, dn;
    bit to;
    launch(make_pkt(8'h40, 5), 5, 5);
    e0 = err_pulses;
    d0 = done_pulses;
    wait_idx(5'd3, 800, to);
    check_cnt++;
    if (to) $display("FAIL ignore_reach_byte3: byte_idx=%0d, expected 3 within budget", byte_idx);
    else pass_cnt++;
    repeat (15) @(negedge clk);
    launch(make_pkt(8'h80, 29), 3, 0);
    launch(make_pkt(8'hC0, 29), 0, 0);
    wait_idle(1000, bc, dn, to);
    repeat (20) @(negedge clk);
    check_cnt++;
    if (to || busy !== 1'b0) $display("FAIL ignore_idle: timeout=%b busy=%b, expected 0 0", to, busy);
    else pass_cnt++;
    check_cnt++;
    if (err_pulses - e0 != 0 || done_pulses - d0 != 1)
      $display("FAIL ignore_pulses: err=%0d done=%0d, expected 0 1", err_pulses - e0, done_pulses - d0);
    else pass_cnt++;
    check_cnt++;
    if (exp_q.size() != 0) $display("FAIL ignore_scoreboard: %0d bytes pending, expected 0", exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_abort();
    int bc, dn, d0, bad;
    bit to;
    launch(make_pkt(8'h55, 4), 4, 2);
    wait_idx(5'd2, 800, to);
    check_cnt++;
    if (to) $display("FAIL abort_reach_byte2: byte_idx=%0d, expected 2 within budget", byte_idx);
    else pass_cnt++;
    rx_discard = 1'b1;
    repeat (34) @(negedge clk);
    d0 = done_pulses;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_cnt++;
    if (tx !== 1'b1 || busy !== 1'b0 || byte_idx !== 5'd0 || done !== 1'b0)
      $display("FAIL abort_next_edge: tx=%b busy=%b idx=%0d done=%b, expected 1 0 0 0", tx, busy, byte_idx, done);
    else pass_cnt++;
    bad = 0;
    for (int i = 0; i < 120; i++) begin
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
      @(negedge clk);
    end
    rx_discard = 1'b0;
    check_cnt++;
    if (bad != 0 || done_pulses != d0) $display("FAIL abort_quiet: %0d active cycles %0d done pulses, expected 0 0", bad, done_pulses - d0);
    else pass_cnt++;
    check_cnt++;
    if (exp_q.size() != 0) $display("FAIL abort_scoreboard: %0d bytes pending, expected 0", exp_q.size());
    else pass_cnt++;
    launch(make_pkt(8'hA5, 1), 1, 1);
    wait_idle(300, bc, dn, to);
    check_cnt++;
    if (to || bc != 2 + 10 * int'(DIV) || dn != 1)
      $display("FAIL abort_restart: busy=%0d done=%0d timeout=%b, expected %0d 1 0", bc, dn, to, 2 + 10 * int'(DIV));
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int bc, dn, bad;
    bit to;
    launch(make_pkt(8'hE0, 29), 3, 1);
    repeat (95) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check_cnt++;
    if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || byte_idx !== 5'd0)
      $display("FAIL reset_mid_state: tx=%b busy=%b done=%b err=%b idx=%0d, expected 1 0 0 0 0", tx, busy, done, err, byte_idx);
    else pass_cnt++;
    reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    check_cnt++;
    if (bad != 0) $display("FAIL reset_mid_quiet: %0d active cycles, expected 0", bad);
    else pass_cnt++;
    launch(make_pkt(8'h3C, 2), 2, 2);
    wait_idle(400, bc, dn, to);
    check_cnt++;
    if (to || bc != 2 + 2 * 10 * int'(DIV) || dn != 1)
      $display("FAIL reset_mid_restart: busy=%0d done=%0d timeout=%b, expected %0d 1 0", bc, dn, to, 2 + 2 * 10 * int'(DIV));
    else pass_cnt++;
    check_cnt++;
    if (exp_q.size() != 0) $display("FAIL reset_mid_scoreboard: %0d bytes pending, expected 0", exp_q.size());
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_long();
    test_err();
    test_busy_ignore();
    test_abort();
    test_reset_mid();
    repeat (150) @(negedge clk);
    check_cnt++;
    if (exp_q.size() != 0) $display("FAIL final_scoreboard: %0d bytes pending, expected 0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
